// File: rtl/rd_req_arbiter.sv
// rd_req_arbiter: round-robin consumer of SLAVE_NUM FWFT read-request FIFOs,
// driving one registered AR channel toward a single downstream master port.
// The winning FIFO index is sent as m_arid so read data can be routed back.
// Optional feature macro: RD_ARB_OUTST_LIMIT_EN adds the rsp_done port and
// caps in-flight reads (including the one held on the AR register) at MAX_OUTST.
module rd_req_arbiter #(
  parameter  int unsigned AWIDTH    = 32,
  parameter  int unsigned SLAVE_NUM = 2,
  parameter  int unsigned MAX_OUTST = 4,
  localparam int unsigned IDW       = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [SLAVE_NUM-1:0]        req,
  input  logic [SLAVE_NUM*AWIDTH-1:0] addr,
  output logic [SLAVE_NUM-1:0]        rd_en,
  output logic [AWIDTH-1:0]           m_araddr,
  output logic [IDW-1:0]              m_arid,
  output logic                        m_arvalid,
  input  logic                        m_arready
`ifdef RD_ARB_OUTST_LIMIT_EN
  ,
  input  logic                        rsp_done
`endif
);

  // Reject meaningless configurations at elaboration
  if (SLAVE_NUM < 1 || MAX_OUTST < 1) begin : g_cfg_err
    $error("rd_req_arbiter: SLAVE_NUM and MAX_OUTST must be >= 1");
  end

  logic              arvalid_q, arvalid_d;
  logic [AWIDTH-1:0] araddr_q, araddr_d;
  logic [IDW-1:0]    arid_q, arid_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    idx;
  logic              free;
  logic              limit_ok;
  logic              grant;
  logic [AWIDTH-1:0] addr_a [SLAVE_NUM];

  assign m_arvalid = arvalid_q;
  assign m_araddr  = araddr_q;
  assign m_arid    = arid_q;

  // Split the flat head-address bus into one entry per FIFO
  for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_unpack
    assign addr_a[i] = addr[i*AWIDTH +: AWIDTH];
  end

`ifdef RD_ARB_OUTST_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ar_hs;
  logic          rsp_dec;

  // Outstanding-read count; a rsp_done with nothing in flight is dropped
  always_comb begin
    ar_hs   = arvalid_q && m_arready;
    rsp_dec = rsp_done && (cnt_q != '0);
    cnt_d   = cnt_q;
    if (ar_hs && !rsp_dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!ar_hs && rsp_dec) begin
      cnt_d = cnt_q - CW'(1);
    end
    limit_ok = (32'(cnt_q) + 32'(arvalid_q)) < MAX_OUTST;
  end

  // Outstanding counter register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign limit_ok = 1'b1;
`endif

  // Round-robin pick: nearest requester after the last grant, wrapping;
  // lower offsets are visited last so they take priority
  always_comb begin
    win = last_q;
    idx = '0;
    for (int unsigned k = SLAVE_NUM; k >= 1; k--) begin
      idx = IDW'((32'(last_q) + k) % SLAVE_NUM);
      if (req[idx]) begin
        win = idx;
      end
    end
  end

  // Grant, pop strobe and next AR register contents
  always_comb begin
    free      = !arvalid_q || m_arready;
    grant     = free && (|req) && limit_ok && !areset;
    rd_en     = '0;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    last_d    = last_q;
    if (grant) begin
      rd_en = SLAVE_NUM'(1) << win;
    end
    if (free) begin
      arvalid_d = grant;
      if (grant) begin
        araddr_d = addr_a[win];
        arid_d   = win;
        last_d   = win;
      end
    end
  end

  // AR register and round-robin pointer; pointer reset makes FIFO 0 win first
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      last_q    <= IDW'(SLAVE_NUM - 1);
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// tb_rd_req_arbiter: randomized scoreboard bench for rd_req_arbiter.
// A reference model predicts pops and queues expected AR beats; a separate
// monitor checks every presented beat and stall stability against the queue.
module tb_rd_req_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned N  = 2;
  localparam int unsigned MO = 2;
  localparam int unsigned IW = 1;

  logic            aclk   = 1'b0;
  logic            areset = 1'b0;
  logic [N-1:0]    req    = '0;
  logic [N*AW-1:0] addr   = '0;
  logic [N-1:0]    rd_en;
  logic [AW-1:0]   m_araddr;
  logic [IW-1:0]   m_arid;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
`ifdef RD_ARB_OUTST_LIMIT_EN
  logic            rsp_done  = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [IW+AW-1:0] exp_q [$];

  rd_req_arbiter #(.AWIDTH(AW), .SLAVE_NUM(N), .MAX_OUTST(MO)) dut (
    .aclk(aclk), .areset(areset), .req(req), .addr(addr), .rd_en(rd_en),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arvalid(m_arvalid),
    .m_arready(m_arready)
`ifdef RD_ARB_OUTST_LIMIT_EN
    , .rsp_done(rsp_done)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Smallest requester above the last grant, otherwise the smallest overall
  function automatic int pick(input logic [N-1:0] r, input int last);
    int above  = -1;
    int lowest = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) begin
        lowest = i;
        if (i > last) above = i;
      end
    end
    return (above >= 0) ? above : lowest;
  endfunction

  // Reference model: predicts rd_en and queues the beat each grant produces
  int m_last  = N - 1;
  int m_valid = 0;
  int m_cnt   = 0;
  always @(negedge aclk) begin
    logic [N-1:0] exp_rd;
    int  g;
    bit  free_m;
    bit  ok;
    if (areset) begin
      m_last  = N - 1;
      m_valid = 0;
      m_cnt   = 0;
      exp_q.delete();
      chk("rd_en_in_reset", rd_en, 0);
    end else begin
      free_m = (m_valid == 0) || m_arready;
      ok = 1'b1;
`ifdef RD_ARB_OUTST_LIMIT_EN
      ok = (m_cnt + m_valid) < MO;
`endif
      g = pick(req, m_last);
      exp_rd = '0;
      if (free_m && ok && g >= 0) exp_rd[g] = 1'b1;
      chk("rd_en", rd_en, exp_rd);
`ifdef RD_ARB_OUTST_LIMIT_EN
      begin
        int inc;
        int dec;
        inc = (m_valid != 0 && m_arready) ? 1 : 0;
        dec = (rsp_done && m_cnt > 0) ? 1 : 0;
        m_cnt = m_cnt + inc - dec;
      end
`endif
      if (free_m) begin
        m_valid = (exp_rd != '0) ? 1 : 0;
        if (m_valid != 0) begin
          exp_q.push_back({IW'(g), addr[g*AW +: AW]});
          m_last = g;
        end
      end
    end
  end

  // Monitor: compares each presented beat with the queue head, checks stalls
  bit               held   = 1'b0;
  logic [IW+AW-1:0] held_v = '0;
  always @(negedge aclk) begin
    logic [IW+AW-1:0] act;
    act = {m_arid, m_araddr};
    if (areset) begin
      held = 1'b0;
      chk("arvalid_in_reset", m_arvalid, 0);
    end else begin
      if (held) begin
        chk("stall_arvalid", m_arvalid, 1);
        chk("stall_payload", act, held_v);
      end
      if (m_arvalid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ar: got id=%0d addr=%0h expected none at %0t",
                   m_arid, m_araddr, $time);
        end else begin
          chk("ar_id_addr", act, exp_q[0]);
          if (m_arready) void'(exp_q.pop_front());
        end
      end
      held   = m_arvalid && !m_arready;
      held_v = act;
    end
  end

  task automatic cyc(input logic [N-1:0] r, input bit rdy, input bit rd);
    req       = r;
    addr      = {$urandom, $urandom};
    m_arready = rdy;
`ifdef RD_ARB_OUTST_LIMIT_EN
    rsp_done  = rd;
`else
    if (rd) begin end
`endif
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #1 areset = 1'b1;
    #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arid", m_arid, 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Both requesting, always ready: FIFO 0 first, then alternating
    repeat (6) cyc(2'b11, 1'b1, 1'b0);
    repeat (3) cyc(2'b11, 1'b1, 1'b1);
    // Random mix
    repeat (200) cyc(N'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30);
    // Backpressure window
    repeat (2) cyc(2'b11, 1'b1, 1'b1);
    repeat (3) cyc(2'b11, 1'b0, 1'b0);
    repeat (3) cyc(2'b11, 1'b1, 1'b1);
    // Single requester
    repeat (8) cyc(2'b10, 1'b1, 1'b1);
    // Reset while a request is held
    repeat (2) cyc(2'b11, 1'b0, 1'b1);
    #2 areset = 1'b1;
    #1;
    chk("midrst_arvalid", m_arvalid, 0);
    chk("midrst_araddr", m_araddr, 0);
    chk("midrst_arid", m_arid, 0);
    @(posedge aclk);
    #1 areset = 1'b0;
    repeat (4) cyc(2'b11, 1'b1, 1'b0);
    // Limit exercise: stall returns, then release one at a time
    repeat (6) cyc(2'b11, 1'b1, 1'b0);
    cyc(2'b11, 1'b1, 1'b1);
    repeat (3) cyc(2'b11, 1'b1, 1'b0);
    // Long random run
    repeat (300) cyc(N'($urandom), $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 40);
    // Drain outstanding expectations within a bounded window
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc(2'b00, 1'b1, 1'b1);
    cyc(2'b00, 1'b1, 1'b1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d beats left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
